// File: rtl/spi_master_burst.sv
// SPI master with CPOL/CPHA modes, MSB/LSB order and multi-word bursts holding CS low between words.
// Optional sticky frame-done interrupt when SPI_MASTER_IRQ_EN is defined.
`timescale 1ns/1ps
module spi_master_burst #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CS        = 4,
    parameter int DIVIDER_WIDTH = 8,
    localparam int CSW          = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_cpol,
    input  logic                     i_cpha,
    input  logic                     i_lsb_first,
    input  logic [DIVIDER_WIDTH-1:0] i_divider,
    input  logic [CSW-1:0]           i_cs_select,
    input  logic                     i_tx_valid,
    output logic                     o_tx_ready,
    input  logic [DATA_WIDTH-1:0]    i_tx_data,
    input  logic                     i_tx_last,
    output logic                     o_rx_valid,
    output logic [DATA_WIDTH-1:0]    o_rx_data,
    output logic                     o_busy,
    output logic                     o_spi_clock,
    output logic [NUM_CS-1:0]        o_spi_cs_n,
    output logic                     o_spi_mosi,
`ifdef SPI_MASTER_IRQ_EN
    input  logic                     i_irq_enable,
    input  logic                     i_irq_clear,
    output logic                     o_irq,
`endif
    input  logic                     i_spi_miso
);
    localparam int EW = $clog2(2 * DATA_WIDTH);
    localparam logic [EW-1:0] LAST_EDGE    = EW'(2 * DATA_WIDTH - 1);
    localparam logic [EW-1:0] LAST_SAMPLE0 = EW'(2 * DATA_WIDTH - 2);

    typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_SHIFT, S_NEXT, S_HOLD, S_DEASSERT} state_t;
    state_t state_q, state_d;

    logic                     cpol_q, cpha_q, lsb_q, last_q;
    logic [DIVIDER_WIDTH-1:0] div_q, cnt_q;
    logic [CSW-1:0]           cs_sel_q, cs_sel_nxt;
    logic [DATA_WIDTH-1:0]    tx_sh_q, rx_sh_q, rx_data_q, rx_nxt;
    logic [EW-1:0]            edge_q;
    logic                     rx_valid_q, sclk_q, mosi_q;
    logic [NUM_CS-1:0]        cs_n_q, cs_n_d;
    logic accept, tick, leading, shift_edge, sample_edge, last_sample, ld_cpha, ld_lsb, cs_on;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // Edge index parity: even edges leave the idle level (leading), odd ones return to it.
    assign tick        = (cnt_q == div_q);
    assign leading     = ~edge_q[0];
    assign shift_edge  = cpha_q ? leading : (!leading && edge_q != LAST_EDGE);
    assign sample_edge = cpha_q ? !leading : leading;
    assign last_sample = sample_edge && (edge_q == (cpha_q ? LAST_EDGE : LAST_SAMPLE0));
    assign ld_cpha     = (state_q == S_IDLE) ? i_cpha : cpha_q;
    assign ld_lsb      = (state_q == S_IDLE) ? i_lsb_first : lsb_q;
    assign rx_nxt      = lsb_q ? {i_spi_miso, rx_sh_q[DATA_WIDTH-1:1]}
                               : {rx_sh_q[DATA_WIDTH-2:0], i_spi_miso};
    assign cs_sel_nxt  = (state_q == S_IDLE && accept) ? i_cs_select : cs_sel_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Handshake: a word transfers on any clock where i_tx_valid && o_tx_ready.
    always_comb begin
        state_d    = state_q;
        o_tx_ready = (state_q == S_IDLE || state_q == S_NEXT) && !i_reset;
        o_busy     = (state_q != S_IDLE);
        accept     = i_tx_valid && o_tx_ready;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_ASSERT;
            S_ASSERT:   if (tick) state_d = S_SHIFT;
            S_SHIFT:    if (tick && edge_q == LAST_EDGE) state_d = last_q ? S_HOLD : S_NEXT;
            S_NEXT:     if (accept) state_d = S_ASSERT;
            S_HOLD:     if (tick) state_d = S_DEASSERT;
            S_DEASSERT: if (tick) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        cs_on  = (state_d == S_ASSERT || state_d == S_SHIFT || state_d == S_NEXT || state_d == S_HOLD);
        cs_n_d = '1;
        for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = !(cs_on && cs_sel_nxt == CSW'(i));
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cpol_q <= 1'b0; cpha_q <= 1'b0; lsb_q <= 1'b0; last_q <= 1'b0;
            div_q <= '0; cnt_q <= '0; cs_sel_q <= '0; edge_q <= '0;
            tx_sh_q <= '0; rx_sh_q <= '0; rx_data_q <= '0; rx_valid_q <= 1'b0;
            sclk_q <= 1'b0; mosi_q <= 1'b0; cs_n_q <= '1;
        end else begin
            rx_valid_q <= 1'b0;
            cs_n_q     <= cs_n_d;
            if (state_q == S_IDLE || state_q == S_NEXT) cnt_q <= '0;
            else cnt_q <= tick ? '0 : cnt_q + DIVIDER_WIDTH'(1);
            if (state_q == S_IDLE) begin
                sclk_q <= i_cpol;
                if (accept) begin
                    cpol_q <= i_cpol; cpha_q <= i_cpha; lsb_q <= i_lsb_first;
                    div_q <= i_divider; cs_sel_q <= i_cs_select;
                end
            end
            // Word load is shared by the first word and every burst continuation.
            if (accept) begin
                last_q <= i_tx_last;
                edge_q <= '0;
                if (ld_cpha) begin
                    tx_sh_q <= i_tx_data;
                end else begin
                    mosi_q  <= first_bit(i_tx_data, ld_lsb);
                    tx_sh_q <= shift_word(i_tx_data, ld_lsb);
                end
            end
            if (state_q == S_SHIFT && tick) begin
                sclk_q <= ~sclk_q;
                edge_q <= (edge_q == LAST_EDGE) ? '0 : edge_q + EW'(1);
                if (shift_edge) begin
                    mosi_q  <= first_bit(tx_sh_q, lsb_q);
                    tx_sh_q <= shift_word(tx_sh_q, lsb_q);
                end
                if (sample_edge) rx_sh_q <= rx_nxt;
                if (last_sample) begin
                    rx_data_q  <= rx_nxt;
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_MASTER_IRQ_EN
    logic irq_q;
    always_ff @(posedge i_clock) begin
        if (i_reset)                                                  irq_q <= 1'b0;
        else if (state_q == S_DEASSERT && tick && i_irq_enable)       irq_q <= 1'b1;
        else if (i_irq_clear)                                         irq_q <= 1'b0;
    end
    assign o_irq = irq_q;
`endif

    assign o_rx_valid  = rx_valid_q;
    assign o_rx_data   = rx_data_q;
    assign o_spi_clock = sclk_q;
    assign o_spi_mosi  = mosi_q;
    assign o_spi_cs_n  = cs_n_q;
endmodule

// File: tb/tb_spi_master_burst.sv
// Scoreboard bench for spi_master_burst: driver pushes expected wire/rx words, monitor pops on o_rx_valid.
// NUM_CS=5 gives a 3-bit select so an out-of-range select (5) is representable.
`timescale 1ns/1ps
module tb_spi_master_burst;
  localparam int DW = 8;
  localparam int NCS = 5;
  localparam int CSW = 3;
  localparam int DIVW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [DIVW-1:0] divider = '0;
  logic [CSW-1:0] cs_select = '0;
  logic tx_valid = 1'b0, tx_last = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic tx_ready, rx_valid, busy, sclk, mosi;
  logic miso = 1'b0;
  logic [DW-1:0] rx_data;
  logic [NCS-1:0] cs_n;
`ifdef SPI_MASTER_IRQ_EN
  logic irq_enable = 1'b0, irq_clear = 1'b0, irq;
`endif

  spi_master_burst #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIVIDER_WIDTH(DIVW)) dut (
    .i_clock(clk), .i_reset(rst), .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb),
    .i_divider(divider), .i_cs_select(cs_select), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .i_tx_data(tx_data), .i_tx_last(tx_last), .o_rx_valid(rx_valid), .o_rx_data(rx_data),
    .o_busy(busy), .o_spi_clock(sclk), .o_spi_cs_n(cs_n), .o_spi_mosi(mosi),
`ifdef SPI_MASTER_IRQ_EN
    .i_irq_enable(irq_enable), .i_irq_clear(irq_clear), .o_irq(irq),
`endif
    .i_spi_miso(miso)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_rx_q[$];
  logic [DW-1:0] exp_wire_q[$];

  // frame config as the bench intends it; written only by the driver
  logic f_cpol = 1'b0, f_cpha = 1'b0;
  int f_div = 0;
  logic [NCS-1:0] exp_cs = '1;
  logic [DW-1:0] slv_wire = '0;
  int load_seq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor + slave model, sampled on the falling clock edge
  int seen_seq = 0, slv_idx = 0, samp_cnt = 0, edge_cnt = 0, last_edge_cyc = 0;
  logic prev_sclk = 1'b0;
  logic [DW-1:0] mosi_w = '0;
  always @(negedge clk) begin
    logic ld;
    logic [DW-1:0] er, ew;
    if (rst) begin
      samp_cnt = 0; edge_cnt = 0; mosi_w = '0;
    end else begin
      if (load_seq != seen_seq) begin
        seen_seq = load_seq;
        slv_idx = 0;
        if (!f_cpha) begin miso = slv_wire[DW-1]; slv_idx = 1; end
      end
      if (busy && sclk != prev_sclk) begin
        ld = (prev_sclk == f_cpol);
        if (edge_cnt != 0) check("half_period", cyc - last_edge_cyc, f_div + 1);
        last_edge_cyc = cyc;
        edge_cnt = (edge_cnt == 2*DW-1) ? 0 : edge_cnt + 1;
        if (f_cpha ? !ld : ld) begin
          mosi_w = {mosi_w[DW-2:0], mosi};
          samp_cnt++;
          check("cs_n_at_sample", cs_n, exp_cs);
        end else if (slv_idx < DW) begin
          miso = slv_wire[DW-1-slv_idx];
          slv_idx++;
        end
      end
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_rx: got rx_data %0h with nothing expected", rx_data);
        end else begin
          er = exp_rx_q.pop_front();
          ew = exp_wire_q.pop_front();
          check("rx_data", rx_data, er);
          check("mosi_wire", mosi_w, ew);
          check("sample_count", samp_cnt, DW);
        end
        samp_cnt = 0;
      end
    end
    prev_sclk = sclk;
  end

  // driver tasks
  task automatic set_cfg(input logic pol, input logic pha, input logic lf, input int dv, input int cs);
    cpol = pol; cpha = pha; lsb = lf; divider = DIVW'(dv); cs_select = CSW'(cs);
    f_cpol = pol; f_cpha = pha; f_div = dv;
    exp_cs = (cs < NCS) ? ~(NCS'(1) << cs) : '1;
    repeat (2) @(negedge clk);
    check("sclk_idle_pre", sclk, pol);
  endtask

  task automatic send(input logic [DW-1:0] tx, input logic last, input logic [DW-1:0] slv,
                      input logic [DW-1:0] wire_exp, input logic [DW-1:0] rx_exp);
    int n = 0;
    tx_valid = 1'b1; tx_data = tx; tx_last = last;
    while (!tx_ready && n < 300) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      n_checks++; n_errors++;
      $display("FAIL tx_ready_timeout: ready=%0b required 1", tx_ready);
      tx_valid = 1'b0;
      return;
    end
    slv_wire = slv; load_seq++;
    exp_rx_q.push_back(rx_exp);
    exp_wire_q.push_back(wire_exp);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_rx_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    check("frame_done", {30'd0, busy, exp_rx_q.size() != 0}, 0);
    @(negedge clk);
    check("sclk_idle_post", sclk, f_cpol);
    check("cs_idle_post", cs_n, {NCS{1'b1}});
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, {NCS{1'b1}});
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
`ifdef SPI_MASTER_IRQ_EN
    check("rst_irq", irq, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", tx_ready, 1);

    // mode 0, divider 1, cs 2
    set_cfg(0, 0, 0, 1, 2);
    send(8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C);
    wait_idle();

    // mode 1, 2, 3 and LSB-first
    set_cfg(0, 1, 0, 0, 0);
    send(8'h01, 1'b1, 8'h96, 8'h01, 8'h96);
    wait_idle();
    set_cfg(1, 0, 0, 2, 1);
    send(8'h01, 1'b1, 8'h5A, 8'h01, 8'h5A);
    wait_idle();
    set_cfg(1, 1, 1, 1, 3);
    send(8'h01, 1'b1, 8'hC0, 8'h80, 8'h03);
    wait_idle();
    set_cfg(0, 0, 1, 0, 4);
    send(8'hB2, 1'b1, 8'h01, 8'h4D, 8'h80);
    wait_idle();

    // three-word burst, 5-cycle stall before word 2, config changes ignored mid-frame
    set_cfg(0, 1, 0, 1, 1);
    send(8'h11, 1'b0, 8'hE1, 8'h11, 8'hE1);
    n = 0;
    while (!tx_ready && n < 300) begin @(negedge clk); n++; end
    check("burst_reach_next", tx_ready, 1);
    cpol = 1'b1; divider = 8'd7; cs_select = 3'd0; lsb = 1'b1; cpha = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_cs_low", cs_n, exp_cs);
      check("gap_sclk_idle", sclk, f_cpol);
      check("gap_busy", busy, 1);
    end
    send(8'h22, 1'b0, 8'h72, 8'h22, 8'h72);
    send(8'h33, 1'b1, 8'h0F, 8'h33, 8'h0F);
    cpol = 1'b0; cpha = 1'b1; lsb = 1'b0; divider = 8'd1; cs_select = 3'd1;
    wait_idle();

    // reset in the middle of the shift phase
    set_cfg(0, 0, 0, 1, 2);
    send(8'h5A, 1'b1, 8'hFF, 8'h5A, 8'hFF);
    n = 0;
    while (samp_cnt < 4 && n < 300) begin @(negedge clk); n++; end
    check("reach_bit4", samp_cnt, 4);
    rst = 1'b1;
    void'(exp_rx_q.pop_back());
    void'(exp_wire_q.pop_back());
    @(negedge clk);
    check("abort_cs_n", cs_n, {NCS{1'b1}});
    check("abort_busy", busy, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_sclk", sclk, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_stays_idle", busy, 0);
    set_cfg(0, 0, 0, 1, 2);
    send(8'hC6, 1'b1, 8'h81, 8'hC6, 8'h81);
    wait_idle();

    // out-of-range chip select still clocks a full word
    set_cfg(1, 1, 0, 3, 5);
    send(8'h3C, 1'b1, 8'hA5, 8'h3C, 8'hA5);
    wait_idle();

`ifdef SPI_MASTER_IRQ_EN
    set_cfg(0, 0, 0, 0, 1);
    irq_enable = 1'b1;
    send(8'hC3, 1'b1, 8'h00, 8'hC3, 8'h00);
    n = 0;
    while (!(busy && cs_n == {NCS{1'b1}}) && n < 300) begin @(negedge clk); n++; end
    check("reach_deassert", busy, 1);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    check("irq_set_wins", irq, 1);
    wait_idle();
    check("irq_sticky", irq, 1);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    check("irq_cleared", irq, 0);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
